// File: rtl/serial_register_loader.sv
// serial_register_loader
// Builds an N-bit word from a framed serial bit stream, sent MSB first and
// followed by one parity bit. A word with good parity is placed on
// data_output and announced by a one-cycle load_signal pulse. A frame with
// bad parity is dropped and reported by a parity_error pulse. A frame that
// stalls is dropped and reported by a timeout_error pulse.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start_signal   frame start strobe; also restarts a frame already in progress
//   bit_valid      qualifies bit_input in this cycle
//   bit_input      serial data bit or parity bit
//   data_output    last word accepted with good parity (registered)
//   load_signal    one-cycle pulse: data_output holds a new word
//   parity_error   one-cycle pulse: frame dropped for bad parity
//   timeout_error  one-cycle pulse: frame dropped for stall
//   busy           high while a frame is in progress
//
// state  | meaning
// IDLE   | no frame in progress; waiting for start_signal
// SHIFT  | collecting the N data bits, MSB first
// PARITY | waiting for the trailing parity bit
module serial_register_loader #(
  parameter int N           = 8,
  parameter bit EVEN_PARITY = 1'b1,
  parameter int TIMEOUT     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_signal,
  input  logic         bit_valid,
  input  logic         bit_input,
  output logic [N-1:0] data_output,
  output logic         load_signal,
  output logic         parity_error,
  output logic         timeout_error,
  output logic         busy
);

  localparam int CW = $clog2(N) + 1;
  // With TIMEOUT = 0 the timeout counter is unused. It keeps one bit so the
  // design never declares a zero-width vector.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [TW-1:0] LAST_IDLE = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  state_t        state;
  logic [N-1:0]  shift_reg;
  logic [CW-1:0] bit_cnt;
  logic [TW-1:0] idle_cnt;
  logic          parity_good;

  // The XOR over the data bits and the parity bit is 0 for a good even-parity
  // frame and 1 for a good odd-parity frame.
  always_comb begin
    parity_good = ((^shift_reg) ^ bit_input) == ~EVEN_PARITY;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      idle_cnt      <= '0;
      data_output   <= '0;
      load_signal   <= 1'b0;
      parity_error  <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      load_signal   <= 1'b0;
      parity_error  <= 1'b0;
      timeout_error <= 1'b0;

      case (state)
        IDLE: begin
          if (start_signal) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
          end
        end

        SHIFT, PARITY: begin
          // A restart has priority over a bit or a timeout arriving in the
          // same cycle, and it raises no error pulse.
          if (start_signal) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
          end else if (bit_valid) begin
            idle_cnt <= '0;
            if (state == SHIFT) begin
              shift_reg <= {shift_reg[N-2:0], bit_input};
              if (bit_cnt == LAST_BIT) begin
                state   <= PARITY;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              state <= IDLE;
              if (parity_good) begin
                data_output <= shift_reg;
                load_signal <= 1'b1;
              end else begin
                parity_error <= 1'b1;
              end
            end
          end else if (TIMEOUT > 0) begin
            if (idle_cnt == LAST_IDLE) begin
              state         <= IDLE;
              bit_cnt       <= '0;
              idle_cnt      <= '0;
              timeout_error <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_register_loader.sv
module tb_serial_register_loader;

  logic       clk;
  logic       reset;
  logic       start_signal;
  logic       bit_valid;
  logic       bit_input;
  logic [7:0] data_output;
  logic       load_signal;
  logic       parity_error;
  logic       timeout_error;
  logic       busy;

  serial_register_loader #(.N(8), .EVEN_PARITY(1'b1), .TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_signal  (start_signal),
    .bit_valid     (bit_valid),
    .bit_input     (bit_input),
    .data_output   (data_output),
    .load_signal   (load_signal),
    .parity_error  (parity_error),
    .timeout_error (timeout_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = load_signal, 1 = parity_error, 2 = timeout_error
  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every pulse must match the next expected event in order. A missing or
  // extra pulse therefore shows up as a miscompare.
  always @(negedge clk) begin
    if (!reset && (load_signal || parity_error || timeout_error)) begin
      check("pulse_onehot", 32'($countones({load_signal, parity_error, timeout_error})), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        int   kind;
        e    = exp_q.pop_front();
        kind = load_signal ? 0 : (parity_error ? 1 : 2);
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_data", 32'(data_output), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start_signal = 1'b1;
    tick();
    start_signal = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) tick();
    bit_valid = 1'b1;
    bit_input = b;
    tick();
    bit_valid = 1'b0;
    bit_input = 1'b0;
  endtask

  // Expected parity outcome is derived from the word and the parity bit.
  task automatic frame(input logic [7:0] w, input logic p, input int gap);
    exp_t e;
    start_frame();
    if (((^w) ^ p) == 1'b0) begin
      last_good = w;
      e.kind = 0;
    end else begin
      e.kind = 1;
    end
    e.data = last_good;
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--) send_bit(w[i], gap);
    send_bit(p, gap);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset        = 1'b1;
    start_signal = 1'b0;
    bit_valid    = 1'b0;
    bit_input    = 1'b0;
    #3;
    check("rst_data_output", 32'(data_output), 32'h0);
    check("rst_load_signal", 32'(load_signal), 32'h0);
    check("rst_parity_error", 32'(parity_error), 32'h0);
    check("rst_timeout_error", 32'(timeout_error), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    #19;
    reset = 1'b0;
    tick();

    // 1: good frame A5
    frame(8'hA5, 1'b0, 0);
    drain("t1_drain");
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_data", 32'(data_output), 32'hA5);

    // 2: same word, bad parity
    frame(8'hA5, 1'b1, 0);
    drain("t2_drain");
    check("t2_data", 32'(data_output), 32'hA5);

    // 3: gaps of 3 idle cycles between bits
    frame(8'h3C, 1'b0, 3);
    drain("t3_drain");
    check("t3_data", 32'(data_output), 32'h3C);

    // 4: stall after 4 bits; the timeout lands on the 16th idle cycle
    start_frame();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    e.kind = 2;
    e.data = last_good;
    exp_q.push_back(e);
    repeat (15) tick();
    check("t4_busy_at_15", 32'(busy), 32'd1);
    check("t4_no_timeout_at_15", 32'(timeout_error), 32'd0);
    tick();
    check("t4_busy_at_16", 32'(busy), 32'd0);
    check("t4_timeout_at_16", 32'(timeout_error), 32'd1);
    drain("t4_drain");
    frame(8'hFF, 1'b0, 0);
    drain("t4_ff_drain");
    check("t4_data", 32'(data_output), 32'hFF);

    // 4b: start on the 16th idle cycle wins over the timeout
    start_frame();
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0);
    repeat (15) tick();
    frame(8'hC3, 1'b0, 0);
    drain("t4b_drain");
    check("t4b_data", 32'(data_output), 32'hC3);

    // 5: restart after 5 bits, then back-to-back frames
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    frame(8'h81, 1'b0, 0);
    check("t5_load_cycle", 32'(load_signal), 32'd1);
    frame(8'h01, 1'b1, 0);
    drain("t5_drain");
    check("t5_data", 32'(data_output), 32'h01);

    // 6: asynchronous reset after 6 bits
    start_frame();
    for (int i = 0; i < 6; i++) send_bit(1'b1, 0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_data_output", 32'(data_output), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_pulses", 32'({load_signal, parity_error, timeout_error}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_good = 8'h00;
    tick();
    frame(8'h5A, 1'b0, 0);
    drain("t6_drain");
    check("t6_data", 32'(data_output), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_register_loader.md
Name: serial_register_loader

Overview:
Upstream feeder for the N-bit load-enabled register. Assembles a framed serial bit stream into an N-bit word, MSB first, and checks a trailing parity bit. Presents each good word on data_output with a one-cycle load_signal pulse, so both connect directly to the register's data_input and load_signal. Rejects frames with bad parity and stalled frames, and reports both as error pulses.

Parameters:
N, 8, word width in bits; must be >= 2.
EVEN_PARITY, 1, 1 = even parity over data plus parity bit; 0 = odd parity.
TIMEOUT, 16, consecutive cycles without bit_valid inside a frame before the frame is aborted; 0 disables the timeout.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
start_signal  input  1  frame start strobe.
bit_valid  input  1  qualifies bit_input in the current cycle.
bit_input  input  1  serial data or parity bit.
data_output  output  N  last word accepted with good parity (registered).
load_signal  output  1  one-cycle pulse: data_output holds a new word.
parity_error  output  1  one-cycle pulse: frame dropped for bad parity.
timeout_error  output  1  one-cycle pulse: frame dropped for stall.
busy  output  1  high while a frame is in progress (SHIFT or PARITY).

Behaviour:
- Reset: one clock, reset asynchronous and active-high.
  - Asserting reset immediately forces state IDLE, shift register 0, bit count 0, timeout count 0.
  - All outputs go to 0 at once: data_output, load_signal, parity_error, timeout_error, busy.
  - Reset mid-frame discards the partial frame and produces no error pulse.
- States: IDLE, SHIFT, PARITY. busy = (state != IDLE), decoded from the registered state.
- IDLE:
  - start_signal=1 -> SHIFT; clear shift register, bit count and timeout count.
  - bit_valid is ignored.
- SHIFT:
  - On bit_valid=1: shift <= {shift[N-2:0], bit_input}; count++.
  - When count = N-1 and bit_valid=1, go to PARITY; that bit is the last data bit.
  - bit_valid=0 holds the shift register and count.
- PARITY:
  - The first bit_valid=1 samples the parity bit and returns the block to IDLE on that same edge.
  - Parity is good when XOR(shift, parity_bit) = 0 if EVEN_PARITY=1, or = 1 if EVEN_PARITY=0.
  - Good parity: data_output <= shift; load_signal=1 for exactly the next cycle.
  - Bad parity: data_output is unchanged; parity_error=1 for exactly the next cycle.
- Latency: load_signal is high in the cycle immediately after the parity bit is sampled. data_output holds its value until the next good frame.
- start_signal while in SHIFT or PARITY:
  - Restarts the frame: clear count, clear shift register, enter SHIFT.
  - No error pulse is produced.
  - start_signal takes priority over a simultaneous bit_valid.
- start_signal in the cycle where load_signal or an error pulse is high (state already IDLE) is accepted normally, so back-to-back frames run with no dead cycle.
- Timeout (TIMEOUT>0):
  - In SHIFT or PARITY, count consecutive cycles with bit_valid=0; the count is cleared on bit_valid=1 and on frame start.
  - On the TIMEOUT-th consecutive idle cycle: go to IDLE, timeout_error=1 for the next cycle, data_output unchanged.
  - start_signal in that same cycle wins: the frame restarts and no timeout_error is raised.
- At most one of load_signal, parity_error, timeout_error is high in any cycle. All three are registered pulses and are never held for more than one cycle.
- Width rules: bit count width is clog2(N)+1; timeout count width is clog2(TIMEOUT+1). Neither counter wraps: both are cleared on state exit.

Test Plan:
1. N=8, EVEN_PARITY=1, TIMEOUT=16: reset, start, bits 1,0,1,0,0,1,0,1 then parity 0 -> data_output=8'hA5, load_signal high exactly one cycle, busy low afterwards.
2. Same frame with parity 1 -> parity_error pulses once, load_signal stays 0, data_output remains 8'hA5.
3. Frame 8'h3C (parity 0) with 3-cycle bit_valid gaps between bits -> data_output=8'h3C, one load_signal pulse, no timeout_error.
4. Start, 4 bits, then bit_valid=0 for 16 cycles -> timeout_error pulses once on the 16th idle cycle, busy falls. A following frame 8'hFF with parity 0 -> data_output=8'hFF.
5. Start, 5 bits, start again, then full frame 8'h81 with parity 0 -> data_output=8'h81 and no error pulses. Issue a second start in the load_signal cycle with frame 8'h01 (parity 1) -> data_output=8'h01, no dead cycle between frames.
6. Assert reset asynchronously after 6 bits of a frame -> all outputs 0 before the next clock edge. After release, frame 8'h5A with parity 0 -> data_output=8'h5A.
